// File: rtl/d_fill_responder.sv
// d_fill_responder: data-cache line-fill responder.
// Fetches 16 words from a word-addressed memory port, returns one 512-bit line.
// Ports: clk, rst (sync, active-high); d_rd_req/d_miss_addr fill request;
//   host_rd_ready/host_rd_data/host_rd_addr line response; fill_err window miss;
//   mem_req/mem_addr/mem_gnt issue side; mem_rvalid/mem_rdata in-order returns.
// Option: CRITICAL_WORD_FIRST_EN starts the fetch at d_miss_addr[3:0], wrapping mod 16.
module d_fill_responder #(
    parameter logic [19:0] WIN_HI          = 20'h00010,
    parameter logic [2:0]  WIN_LO_MIN      = 3'd1,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         d_rd_req,
    input  logic [31:0]  d_miss_addr,
    output logic         host_rd_ready,
    output logic [512:0] host_rd_data,
    output logic [31:0]  host_rd_addr,
    output logic         fill_err,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP,
        HOLD
    } state_t;

    state_t       state;
    logic [27:0]  base_hi;
    logic [4:0]   issue_cnt;
    logic [4:0]   recv_cnt;
    logic [511:0] line;
    logic [511:0] rd_line;

    logic         in_win;
    logic         issued;
    logic         recv;
    logic [4:0]   issue_nx;
    logic [4:0]   recv_nx;
    logic [4:0]   out_nx;
    logic         req_nx;
    logic [3:0]   issue_idx;
    logic [3:0]   recv_idx;
    logic [511:0] line_nx;

    assign in_win = (d_miss_addr[31:12] == WIN_HI) &&
                    (d_miss_addr[11:9] >= WIN_LO_MIN);

    // Bit 512 of the response is reserved and always zero.
    assign host_rd_data = {1'b0, rd_line};

    always_comb begin
        issued   = (state == FETCH) && mem_req && mem_gnt;
        recv     = (state == FETCH) && mem_rvalid;
        issue_nx = issue_cnt + {4'b0, issued};
        recv_nx  = recv_cnt + {4'b0, recv};
        out_nx   = issue_nx - recv_nx;
        // Outstanding never grows while a request waits for grant, so a
        // raised mem_req stays raised until it is accepted.
        req_nx   = (issue_nx < 5'd16) &&
                   (out_nx < 5'(MAX_OUTSTANDING));
    end

`ifdef CRITICAL_WORD_FIRST_EN
    logic [3:0] start;

    always_ff @(posedge clk) begin
        if (rst) begin
            start <= '0;
        end else if (state == IDLE && d_rd_req) begin
            start <= d_miss_addr[3:0];
        end
    end

    // 4-bit add wraps 15 -> 0, so the fetch never leaves the line.
    always_comb begin
        issue_idx = start + issue_nx[3:0];
        recv_idx  = start + recv_cnt[3:0];
    end
`else
    wire unused_start = ^d_miss_addr[3:0];

    always_comb begin
        issue_idx = issue_nx[3:0];
        recv_idx  = recv_cnt[3:0];
    end
`endif

    always_comb begin
        line_nx = line;
        if (recv) begin
            line_nx[{recv_idx, 5'b0} +: 32] = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            base_hi       <= '0;
            issue_cnt     <= '0;
            recv_cnt      <= '0;
            line          <= '0;
            rd_line       <= '0;
            host_rd_ready <= 1'b0;
            host_rd_addr  <= '0;
            fill_err      <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
        end else begin
            host_rd_ready <= 1'b0;
            fill_err      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (d_rd_req) begin
                        base_hi   <= d_miss_addr[31:4];
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        if (in_win) begin
                            state <= FETCH;
                        end else begin
                            fill_err <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                end
                FETCH: begin
                    issue_cnt <= issue_nx;
                    recv_cnt  <= recv_nx;
                    line      <= line_nx;
                    mem_req   <= req_nx;
                    mem_addr  <= {base_hi, issue_idx};
                    if (recv_nx == 5'd16) begin
                        // Response registers load on entry so they are
                        // valid during the single RESP cycle.
                        state         <= RESP;
                        mem_req       <= 1'b0;
                        host_rd_ready <= 1'b1;
                        rd_line       <= line_nx;
                        host_rd_addr  <= {base_hi, 4'h0};
                    end
                end
                RESP: begin
                    state <= HOLD;
                end
                HOLD: begin
                    // Requester may still hold d_rd_req this cycle.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
